// File: rtl/alu_1bit_if.sv
// Bus bundle for one 1-bit ALU slice: operand/control inputs and all
// function outputs. The optional overflow signal is present only when
// ALU1BIT_OVF_EN is defined.
interface alu_1bit_if;
    logic       a;
    logic       b;
    logic       cin;
    logic       less;
    logic [2:0] op;
    logic       result;
    logic       cout;
    logic       g;
    logic       p;
    logic       set;
`ifdef ALU1BIT_OVF_EN
    logic       overflow;
`endif

    // Driver side: supplies operands and op code, observes outputs
    modport master (
        output a, b, cin, less, op,
`ifdef ALU1BIT_OVF_EN
        input  overflow,
`endif
        input  result, cout, g, p, set
    );

    // ALU slice side
    modport slave (
        input  a, b, cin, less, op,
`ifdef ALU1BIT_OVF_EN
        output overflow,
`endif
        output result, cout, g, p, set
    );
endinterface

// File: rtl/alu_1bit.sv
// One-bit ALU slice (AND / OR / ADD-SUB / SLT with optional B inversion).
// The carry/lookahead outputs (cout, g, p, set) are combinational so slices
// can be chained; only result is registered.
// Optional feature macro: ALU1BIT_OVF_EN adds the combinational overflow
// output (cin ^ cout) used on the MSB slice for signed overflow.
module alu_1bit (
    input  logic       clk,
    input  logic       rst_n,
    alu_1bit_if.slave  bus
);

    localparam logic [1:0] FN_AND  = 2'b00;
    localparam logic [1:0] FN_OR   = 2'b01;
    localparam logic [1:0] FN_SUM  = 2'b10;
    localparam logic [1:0] FN_LESS = 2'b11;

    // Full adder: returns {carry, sum}
    function automatic logic [1:0] full_add(
        input logic x,
        input logic y,
        input logic c
    );
        logic s;
        logic co;
        s  = x ^ y ^ c;
        co = (x & y) | (x & c) | (y & c);
        return {co, s};
    endfunction

    logic       bb_s;
    logic [1:0] add_s;
    logic       g_s;
    logic       p_s;
    logic       next_result_s;
    logic       result_r;

    // Operand conditioning, adder and lookahead terms, result selection
    always_comb begin
        bb_s          = bus.b ^ bus.op[2];
        add_s         = full_add(bus.a, bb_s, bus.cin);
        g_s           = bus.a & bb_s;
        p_s           = bus.a | bb_s;
        next_result_s = 1'b0;
        case (bus.op[1:0])
            FN_AND:  next_result_s = g_s;
            FN_OR:   next_result_s = p_s;
            FN_SUM:  next_result_s = add_s[0];
            FN_LESS: next_result_s = bus.less;
            default: next_result_s = 1'b0;
        endcase
    end

    // Result register, cleared asynchronously while rst_n is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= 1'b0;
        end else begin
            result_r <= next_result_s;
        end
    end

    assign bus.result = result_r;
    assign bus.cout   = add_s[1];
    assign bus.g      = g_s;
    assign bus.p      = p_s;
    assign bus.set    = add_s[0];
`ifdef ALU1BIT_OVF_EN
    assign bus.overflow = bus.cin ^ add_s[1];
`endif

endmodule

// File: tb/tb_alu_1bit.sv
// Self-checking bench for alu_1bit: directed cases, reset behaviour,
// an exhaustive sweep of {a,b,cin,less,op} and random stimulus, all
// checked against an arithmetic reference model.
module tb_alu_1bit;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_1bit_if bus_if ();

    alu_1bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer sum of a + (b xor binvert) + cin
    function automatic int ref_sum(input logic a, input logic b, input logic cin, input logic [2:0] op);
        int bb;
        bb = (op[2] == 1'b1) ? (1 - int'(b)) : int'(b);
        return int'(a) + bb + int'(cin);
    endfunction

    function automatic logic ref_result(input logic a, input logic b, input logic cin,
                                        input logic less, input logic [2:0] op);
        int bb;
        int s;
        bb = (op[2] == 1'b1) ? (1 - int'(b)) : int'(b);
        s  = int'(a) + bb + int'(cin);
        case (op[1:0])
            2'd0:    return ((int'(a) * bb) != 0);
            2'd1:    return ((int'(a) + bb) != 0);
            2'd2:    return ((s % 2) == 1);
            default: return less;
        endcase
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one vector, check combinational outputs, then result after the edge
    task automatic run_vec(input logic a, input logic b, input logic cin,
                           input logic less, input logic [2:0] op);
        int  s;
        int  bb;
        logic cout_e;
        @(negedge clk);
        bus_if.a    = a;
        bus_if.b    = b;
        bus_if.cin  = cin;
        bus_if.less = less;
        bus_if.op   = op;
        #1;
        s      = ref_sum(a, b, cin, op);
        bb     = s - int'(a) - int'(cin);
        cout_e = (s >= 2);
        check("cout",  bus_if.cout, cout_e);
        check("set",   bus_if.set,  ((s % 2) == 1));
        check("g",     bus_if.g,    ((int'(a) * bb) != 0));
        check("p",     bus_if.p,    ((int'(a) + bb) != 0));
        check("lookahead", bus_if.cout, bus_if.g | (bus_if.p & cin));
`ifdef ALU1BIT_OVF_EN
        check("overflow", bus_if.overflow, cin ^ cout_e);
`endif
        @(posedge clk);
        #1;
        check("result", bus_if.result, ref_result(a, b, cin, less, op));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_if.a    = 1'b0;
        bus_if.b    = 1'b0;
        bus_if.cin  = 1'b0;
        bus_if.less = 1'b0;
        bus_if.op   = 3'b000;

        // Reset state
        @(posedge clk);
        #1;
        check("reset_state", bus_if.result, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_vec(1'b1, 1'b0, 1'b0, 1'b0, 3'b100);  // AND-NOT
        check("andnot_res", bus_if.result, 1'b1);
        run_vec(1'b0, 1'b0, 1'b0, 1'b1, 3'b111);  // SLT pass-through
        check("slt_res", bus_if.result, 1'b1);
        run_vec(1'b1, 1'b1, 1'b0, 1'b0, 3'b010);  // ADD carry
        check("add_res", bus_if.result, 1'b0);
        run_vec(1'b1, 1'b1, 1'b1, 1'b0, 3'b010);  // ADD carry-in
        check("addci_res", bus_if.result, 1'b1);

        // Asynchronous reset mid-cycle with result=1
        run_vec(1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
        check("pre_reset_one", bus_if.result, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus_if.result, 1'b0);
        @(posedge clk);
        #1;
        check("held_in_reset", bus_if.result, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_release", bus_if.result, 1'b0);
        @(posedge clk);
        #1;
        check("first_edge", bus_if.result, 1'b1);

        // Exhaustive sweep of all input combinations
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            run_vec(v[6], v[5], v[4], v[3], v[2:0]);
        end

        // Random stimulus
        for (int i = 0; i < 200; i++) begin
            logic [6:0] r;
            r = 7'($urandom_range(0, 127));
            run_vec(r[6], r[5], r[4], r[3], r[2:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
